// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: operand/request side and result side.
// The design connects through the slave modport; producers/consumers use master.
interface shifter_pipe_if #(
  parameter int unsigned DATA  = 8,
  parameter int unsigned SHAMT = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA-1:0]   in;
  logic [SHAMT-1:0]  shamt;
  logic [2:0]        op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA-1:0]   out;
  logic              busy;

  modport master (
    output in_valid, in, shamt, op, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in, shamt, op, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter. Shift level b (amount 2^b) is applied in the logic
// feeding stage floor(b*STAGES/SHAMT); each stage carries data, op and shamt.
// Per-stage load enables collapse bubbles and propagate back-pressure.
module shifter_pipe #(
  parameter int unsigned DATA   = 8,
  parameter int unsigned SHAMT  = 3,
  parameter int unsigned STAGES = 1
) (
  input  logic         clk,
  input  logic         reset,
  shifter_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  logic [STAGES-1:0] v_q, v_d;
  logic [DATA-1:0]   data_q [STAGES];
  logic [DATA-1:0]   data_d [STAGES];
  logic [2:0]        op_q   [STAGES];
  logic [2:0]        op_d   [STAGES];
  logic [SHAMT-1:0]  sh_q   [STAGES];
  logic [SHAMT-1:0]  sh_d   [STAGES];
  logic [STAGES:0]   ld;

  logic              src_v;
  logic [DATA-1:0]   src_data;
  logic [2:0]        src_op;
  logic [SHAMT-1:0]  src_sh;

  // One shift level by a fixed amount; 1 <= amt < DATA always holds here.
  // For SRA the current MSB equals the original operand's MSB, since earlier
  // levels only ever replicated it.
  function automatic logic [DATA-1:0] shift_level(
    input logic [DATA-1:0] d,
    input logic [2:0]      op,
    input int unsigned     amt
  );
    logic [DATA-1:0] r;
    case (op_e'(op))
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | ({DATA{d[DATA-1]}} << (DATA - amt));
      OP_ROL:  r = (d << amt) | (d >> (DATA - amt));
      OP_ROR:  r = (d >> amt) | (d << (DATA - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // Load enables: a stage may load if it is empty or its occupant moves on.
  always_comb begin
    ld = '0;
    ld[STAGES] = bus.out_ready;
    for (int unsigned j = 0; j < STAGES; j++) begin
      ld[STAGES-1-j] = !v_q[STAGES-1-j] || ld[STAGES-j];
    end
  end

  // Next-state per stage: take upstream entry (with its levels applied) or hold.
  always_comb begin
    src_v    = 1'b0;
    src_data = '0;
    src_op   = '0;
    src_sh   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_v    = bus.in_valid;
        src_data = bus.in;
        src_op   = bus.op;
        src_sh   = bus.shamt;
      end else begin
        src_v    = v_q[(k > 0) ? k - 1 : 0];
        src_data = data_q[(k > 0) ? k - 1 : 0];
        src_op   = op_q[(k > 0) ? k - 1 : 0];
        src_sh   = sh_q[(k > 0) ? k - 1 : 0];
      end
      for (int unsigned b = 0; b < SHAMT; b++) begin
        if (((b * STAGES) / SHAMT) == k && src_sh[b]) begin
          src_data = shift_level(src_data, src_op, 1 << b);
        end
      end
      v_d[k]    = v_q[k];
      data_d[k] = data_q[k];
      op_d[k]   = op_q[k];
      sh_d[k]   = sh_q[k];
      if (ld[k]) begin
        v_d[k]    = src_v;
        data_d[k] = src_data;
        op_d[k]   = src_op;
        sh_d[k]   = src_sh;
      end
    end
  end

  // Stage registers; reset only clears the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      data_q[k] <= data_d[k];
      op_q[k]   <= op_d[k];
      sh_q[k]   <= sh_d[k];
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out       = v_q[STAGES-1] ? data_q[STAGES-1] : '0;
  assign bus.busy      = |v_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and random checks of shifter_pipe with STAGES = 1, 2 and 3
// instantiated side by side (instance index g has STAGES = g+1).
module tb_shifter_pipe;

  localparam logic [2:0] SLL = 3'd0, SRL = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [2:0]      in_valid_t, out_ready_t;
  logic [2:0][7:0] in_t;
  logic [2:0][2:0] shamt_t, op_t;
  logic [2:0]      in_ready_o, out_valid_o, busy_o;
  logic [2:0][7:0] out_o;

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shifter_pipe_if #(.DATA(8), .SHAMT(3)) bus ();
    assign bus.in_valid  = in_valid_t[g];
    assign bus.in        = in_t[g];
    assign bus.shamt     = shamt_t[g];
    assign bus.op        = op_t[g];
    assign bus.out_ready = out_ready_t[g];
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;
    assign out_o[g]       = bus.out;
    assign busy_o[g]      = bus.busy;
    shifter_pipe #(.DATA(8), .SHAMT(3), .STAGES(g + 1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic [2:0] op);
    case (op)
      SLL:     return d << s;
      SRL:     return d >> s;
      SRA:     return 8'($signed(d) >>> s);
      ROL:     return (d << s) | (d >> (8 - s));
      ROR:     return (d >> s) | (d << (8 - s));
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d,
                       input logic [2:0] s, input logic [2:0] op);
    in_valid_t[i] = v;
    in_t[i]       = d;
    shamt_t[i]    = s;
    op_t[i]       = op;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid s%0d: got %b want 0", i + 1, out_valid_o[i]);
      end
      vectors++;
      if (busy_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy s%0d: got %b want 0", i + 1, busy_o[i]);
      end
      vectors++;
      if (in_ready_o[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready s%0d: got %b want 1", i + 1, in_ready_o[i]);
      end
      vectors++;
      if (out_o[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_out s%0d: got %h want 00", i + 1, out_o[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_rol_sweep();
    logic [7:0] expv [8];
    expv = '{8'h9C, 8'h39, 8'h72, 8'hE4, 8'hC9, 8'h93, 8'h27, 8'h4E};
    out_ready_t[0] = 1'b1;
    for (int s = 0; s < 8; s++) begin
      drive(0, 1'b1, 8'b10011100, 3'(s), ROL);
      #1;
      vectors++;
      if (in_ready_o[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_in_ready sh=%0d: got %b want 1", s, in_ready_o[0]);
      end
      tick();
      vectors++;
      if (out_valid_o[0] !== 1'b1 || out_o[0] !== expv[s]) begin
        miscompares++;
        $display("FAIL sweep_out sh=%0d: got v=%b %h want v=1 %h", s, out_valid_o[0],
                 out_o[0], expv[s]);
      end
    end
    in_valid_t[0] = 1'b0;
    tick();
    vectors++;
    if (out_valid_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_drained: got out_valid %b want 0", out_valid_o[0]);
    end
  endtask

  task automatic test_ops_latency();
    logic [2:0] opv [6];
    logic [2:0] shv [6];
    logic [7:0] expv [6];
    opv  = '{SRA, SRL, SLL, ROR, 3'd5, SRA};
    shv  = '{3'd2, 3'd2, 3'd3, 3'd1, 3'd5, 3'd0};
    expv = '{8'hE7, 8'h27, 8'hE0, 8'h4E, 8'h9C, 8'h9C};
    out_ready_t[2] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      drive(2, 1'b1, 8'h9C, shv[t], opv[t]);
      tick();
      in_valid_t[2] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        vectors++;
        if (out_valid_o[2] !== ((c == 3) ? 1'b1 : 1'b0)) begin
          miscompares++;
          $display("FAIL ops_latency t%0d c%0d: got out_valid %b want %b", t, c,
                   out_valid_o[2], (c == 3));
        end
        if (c < 3) tick();
      end
      vectors++;
      if (out_o[2] !== expv[t]) begin
        miscompares++;
        $display("FAIL ops_result t%0d op=%0d sh=%0d: got %h want %h", t, opv[t], shv[t],
                 out_o[2], expv[t]);
      end
      tick();
      vectors++;
      if (out_valid_o[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL ops_consumed t%0d: got out_valid %b want 0", t, out_valid_o[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] opv [5];
    logic [2:0] shv [5];
    logic [7:0] expv [5];
    opv  = '{SLL, SRL, SRA, ROL, ROR};
    shv  = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd6};
    expv = '{8'h4A, 8'h14, 8'hFA, 8'hD2, 8'h96};
    out_ready_t[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b1, 8'hA5, shv[k], opv[k]);
      #1;
      vectors++;
      if (in_ready_o[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_accept k%0d: got in_ready %b want 1", k, in_ready_o[2]);
      end
      tick();
    end
    drive(2, 1'b1, 8'hA5, shv[3], opv[3]);
    for (int h = 0; h < 2; h++) begin
      #1;
      vectors++;
      if (in_ready_o[2] !== 1'b0 || busy_o[2] !== 1'b1 || out_valid_o[2] !== 1'b1 ||
          out_o[2] !== expv[0]) begin
        miscompares++;
        $display("FAIL b2b_full h%0d: got rdy=%b busy=%b v=%b out=%h want 0 1 1 %h", h,
                 in_ready_o[2], busy_o[2], out_valid_o[2], out_o[2], expv[0]);
      end
      if (h == 0) tick();
    end
    out_ready_t[2] = 1'b1;
    #1;
    vectors++;
    if (in_ready_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_return: got in_ready %b want 1", in_ready_o[2]);
    end
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (out_valid_o[2] !== 1'b1 || out_o[2] !== expv[j] || in_ready_o[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_drain j%0d: got v=%b out=%h rdy=%b want 1 %h 1", j,
                 out_valid_o[2], out_o[2], in_ready_o[2], expv[j]);
      end
      tick();
      if (j == 0) drive(2, 1'b1, 8'hA5, shv[4], opv[4]);
      if (j == 1) in_valid_t[2] = 1'b0;
      #1;
    end
    vectors++;
    if (out_valid_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty: got v=%b busy=%b want 0 0", out_valid_o[2], busy_o[2]);
    end
  endtask

  task automatic test_bubble();
    out_ready_t[2] = 1'b0;
    drive(2, 1'b1, 8'h3C, 3'd5, ROL);
    #1;
    vectors++;
    if (in_ready_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL bubble_accept_a: got in_ready %b want 1", in_ready_o[2]);
    end
    tick();
    in_valid_t[2] = 1'b0;
    tick();
    tick();
    drive(2, 1'b1, 8'hF0, 3'd2, SRA);
    #1;
    vectors++;
    if (in_ready_o[2] !== 1'b1 || out_valid_o[2] !== 1'b1 || out_o[2] !== 8'h87) begin
      miscompares++;
      $display("FAIL bubble_accept_b: got rdy=%b v=%b out=%h want 1 1 87", in_ready_o[2],
               out_valid_o[2], out_o[2]);
    end
    tick();
    in_valid_t[2] = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy_o[2] !== 1'b1 || in_ready_o[2] !== 1'b1 || out_o[2] !== 8'h87) begin
      miscompares++;
      $display("FAIL bubble_hold: got busy=%b rdy=%b out=%h want 1 1 87", busy_o[2],
               in_ready_o[2], out_o[2]);
    end
    out_ready_t[2] = 1'b1;
    #1;
    vectors++;
    if (out_valid_o[2] !== 1'b1 || out_o[2] !== 8'h87) begin
      miscompares++;
      $display("FAIL bubble_out_a: got v=%b out=%h want 1 87", out_valid_o[2], out_o[2]);
    end
    tick();
    vectors++;
    if (out_valid_o[2] !== 1'b1 || out_o[2] !== 8'hFC) begin
      miscompares++;
      $display("FAIL bubble_out_b: got v=%b out=%h want 1 FC", out_valid_o[2], out_o[2]);
    end
    tick();
    vectors++;
    if (out_valid_o[2] !== 1'b0 || busy_o[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_empty: got v=%b busy=%b want 0 0", out_valid_o[2], busy_o[2]);
    end
  endtask

  task automatic test_reset_flush();
    out_ready_t[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b1, 8'h5A + 8'(k), 3'(k + 1), SLL);
      tick();
    end
    in_valid_t[2] = 1'b0;
    #1;
    vectors++;
    if (busy_o[2] !== 1'b1 || out_valid_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre: got busy=%b v=%b want 1 1", busy_o[2], out_valid_o[2]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid_o[2] !== 1'b0 || busy_o[2] !== 1'b0 || in_ready_o[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_post: got v=%b busy=%b rdy=%b want 0 0 1", out_valid_o[2],
               busy_o[2], in_ready_o[2]);
    end
    out_ready_t[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if (out_valid_o[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_stale c%0d: got out_valid %b out=%h want 0", c,
                 out_valid_o[2], out_o[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] sb [3][1024];
    int wr [3];
    int rd [3];
    int cnt [3];
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0;
      rd[i] = 0;
      cnt[i] = 0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10040; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (c < 10000) begin
          drive(i, ($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 3'($urandom));
          out_ready_t[i] = ($urandom_range(0, 2) != 0);
        end else begin
          in_valid_t[i]  = 1'b0;
          out_ready_t[i] = 1'b1;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (out_valid_o[i] && out_ready_t[i]) begin
          vectors++;
          if (cnt[i] == 0) begin
            miscompares++;
            $display("FAIL rand_extra s%0d: got %h with nothing outstanding", i + 1, out_o[i]);
          end else begin
            if (out_o[i] !== sb[i][rd[i]]) begin
              miscompares++;
              $display("FAIL rand_out s%0d: got %h want %h", i + 1, out_o[i], sb[i][rd[i]]);
            end
            rd[i] = (rd[i] + 1) % 1024;
            cnt[i]--;
          end
        end
        if (in_valid_t[i] && in_ready_o[i]) begin
          sb[i][wr[i]] = ref_shift(in_t[i], shamt_t[i], op_t[i]);
          wr[i] = (wr[i] + 1) % 1024;
          cnt[i]++;
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (cnt[i] != 0 || busy_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_drain s%0d: got %0d outstanding busy=%b want 0 0", i + 1,
                 cnt[i], busy_o[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid_t  = '0;
    out_ready_t = '0;
    in_t        = '0;
    shamt_t     = '0;
    op_t        = '0;
    test_reset();
    test_rol_sweep();
    test_ops_latency();
    test_back_to_back();
    test_bubble();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
